disp_cmd_seq: RTL and testbench

Command sequencer between the host command FIFO reader and the display's framebuffer/config resources. It consumes the byte stream latched from the FIFO, decodes multi-byte commands, and issues framebuffer writes through a port shared with the scan-out logic, which always has priority. It also issues configuration-register writes.

---
 rtl/disp_cmd_seq.sv | 183 ++++++++++++++++++
 tb/tb_disp_cmd_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_cmd_seq.sv
// rtl/disp_cmd_seq.sv - host command byte sequencer for framebuffer and config register writes
// Optional feature macro: CMDSEQ_ERRCNT_EN (unknown-opcode counter on err_count)
module disp_cmd_seq #(
    parameter int ADDR_W    = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [7:0]           cmd_byte,
    input  logic                 cmd_avail,
    output logic                 cmd_ack,
    input  logic                 disp_busy,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 reg_we,
    output logic [REG_IDX_W-1:0] reg_idx,
    output logic [7:0]           reg_wdata,
    output logic                 seq_busy,
    output logic [7:0]           err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_WR_LEN,
        S_WR_DATA,
        S_WR_COMMIT,
        S_REG_IDX,
        S_REG_VAL
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [8:0]             count_q, count_d;
    logic [7:0]             lo_q, lo_d;
    logic [7:0]             data_q, data_d;
    logic [REG_IDX_W-1:0]   idx_q, idx_d;
    logic                   cmd_ack_q;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;
    logic                   reg_we_q, reg_we_d;
    logic [REG_IDX_W-1:0]   reg_idx_q, reg_idx_d;
    logic [7:0]             reg_wdata_q, reg_wdata_d;
    logic                   seq_busy_q;
    logic                   accept;
    logic [15:0]            set_addr;

    // A byte is taken only outside the ack cycle and never while a write is pending
    assign accept   = cmd_avail && !cmd_ack_q && (state_q != S_WR_COMMIT);
    assign set_addr = {cmd_byte, lo_q};

`ifdef CMDSEQ_ERRCNT_EN
    logic [7:0] err_q, err_d;
    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

    // Next-state decode and datapath updates; scan-out keeps port priority in WR_COMMIT
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        lo_d        = lo_q;
        data_d      = data_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_we_d    = 1'b0;
        reg_idx_d   = reg_idx_q;
        reg_wdata_d = reg_wdata_q;
`ifdef CMDSEQ_ERRCNT_EN
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                case (cmd_byte)
                    8'h00: state_d = S_IDLE;
                    8'h01: state_d = S_ADDR_LO;
                    8'h02: state_d = S_WR_LEN;
                    8'h03: state_d = S_REG_IDX;
                    default: begin
`ifdef CMDSEQ_ERRCNT_EN
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_ADDR_LO: if (accept) begin
                lo_d    = cmd_byte;
                state_d = S_ADDR_HI;
            end
            S_ADDR_HI: if (accept) begin
                addr_d     = set_addr[ADDR_W-1:0];
                mem_addr_d = set_addr[ADDR_W-1:0];
                state_d    = S_IDLE;
            end
            S_WR_LEN: if (accept) begin
                count_d = (cmd_byte == 8'd0) ? 9'd256 : {1'b0, cmd_byte};
                state_d = S_WR_DATA;
            end
            S_WR_DATA: if (accept) begin
                data_d  = cmd_byte;
                state_d = S_WR_COMMIT;
            end
            S_WR_COMMIT: if (!disp_busy) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = data_q;
                addr_d      = addr_q + ADDR_W'(1);
                count_d     = count_q - 9'd1;
                state_d     = (count_q != 9'd1) ? S_WR_DATA : S_IDLE;
            end
            S_REG_IDX: if (accept) begin
                idx_d   = cmd_byte[REG_IDX_W-1:0];
                state_d = S_REG_VAL;
            end
            S_REG_VAL: if (accept) begin
                reg_idx_d   = idx_q;
                reg_wdata_d = cmd_byte;
                reg_we_d    = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any partial command and strobes at once
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            lo_q        <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            cmd_ack_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_idx_q   <= '0;
            reg_wdata_q <= '0;
            seq_busy_q  <= 1'b0;
`ifdef CMDSEQ_ERRCNT_EN
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            lo_q        <= lo_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            cmd_ack_q   <= accept;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_idx_q   <= reg_idx_d;
            reg_wdata_q <= reg_wdata_d;
            seq_busy_q  <= (state_d != S_IDLE);
`ifdef CMDSEQ_ERRCNT_EN
            err_q       <= err_d;
`endif
        end
    end

    assign cmd_ack   = cmd_ack_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_idx   = reg_idx_q;
    assign reg_wdata = reg_wdata_q;
    assign seq_busy  = seq_busy_q;

endmodule

// File: tb/tb_disp_cmd_seq.sv
// tb/tb_disp_cmd_seq.sv - scoreboard testbench for disp_cmd_seq
module tb_disp_cmd_seq;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  cmd_byte;
    logic        cmd_avail;
    logic        cmd_ack;
    logic        disp_busy;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        reg_we;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_wdata;
    logic        seq_busy;
    logic [7:0]  err_count;

    typedef struct packed { logic [15:0] a; logic [7:0] d; } mem_exp_t;
    typedef struct packed { logic [3:0] i; logic [7:0] d; } reg_exp_t;

    mem_exp_t exp_mem[$];
    reg_exp_t exp_reg[$];
    mem_exp_t me;
    reg_exp_t re;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;

    disp_cmd_seq #(.ADDR_W(16), .REG_IDX_W(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_byte  (cmd_byte),
        .cmd_avail (cmd_avail),
        .cmd_ack   (cmd_ack),
        .disp_busy (disp_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .reg_we    (reg_we),
        .reg_idx   (reg_idx),
        .reg_wdata (reg_wdata),
        .seq_busy  (seq_busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack();
        int  n   = 0;
        bit  got = 0;
        while (!got && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (cmd_ack) got = 1;
        end
        cmd_avail = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=no_ack expected=ack byte=%0h", cmd_byte);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cmd_byte  = b;
        cmd_avail = 1'b1;
        wait_ack();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [15:0] a, input logic [7:0] d);
        mem_exp_t x;
        x.a = a;
        x.d = d;
        exp_mem.push_back(x);
    endtask

    task automatic push_reg(input logic [3:0] i, input logic [7:0] d);
        reg_exp_t x;
        x.i = i;
        x.d = d;
        exp_reg.push_back(x);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        check({tag, "_cmd_ack"},   {31'd0, cmd_ack},   32'd0);
        check({tag, "_reg_we"},    {31'd0, reg_we},    32'd0);
        check({tag, "_seq_busy"},  {31'd0, seq_busy},  32'd0);
        check({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, "_reg_idx"},   {28'd0, reg_idx},   32'd0);
        check({tag, "_reg_wdata"}, {24'd0, reg_wdata}, 32'd0);
        check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
    endtask

    // Monitor: compare every write strobe against the scoreboard, count ack pulses
    always @(negedge clk) begin
        if (nrst) begin
            if (cmd_ack) ack_cnt++;
            if (mem_we) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_we actual=%0h@%0h expected=none", mem_wdata, mem_addr);
                end else begin
                    me = exp_mem.pop_front();
                    check("mem_addr", {16'd0, mem_addr}, {16'd0, me.a});
                    check("mem_wdata", {24'd0, mem_wdata}, {24'd0, me.d});
                end
            end
            if (reg_we) begin
                if (exp_reg.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_reg_we actual=%0h@%0h expected=none", reg_wdata, reg_idx);
                end else begin
                    re = exp_reg.pop_front();
                    check("reg_idx", {28'd0, reg_idx}, {28'd0, re.i});
                    check("reg_wdata", {24'd0, reg_wdata}, {24'd0, re.d});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        nrst      = 1'b0;
        cmd_byte  = 8'h00;
        cmd_avail = 1'b0;
        disp_busy = 1'b0;
        idle_cycles(2);
        check_reset_outputs("por");
        nrst = 1'b1;
        idle_cycles(1);

        // SET_ADDR 0x1234, WRITE 3 bytes
        ack_cnt = 0;
        push_mem(16'h1234, 8'hAA);
        push_mem(16'h1235, 8'hBB);
        push_mem(16'h1236, 8'hCC);
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        idle_cycles(4);
        check("write_ack_count", ack_cnt, 32'd8);
        check("write_seq_busy_end", {31'd0, seq_busy}, 32'd0);
        check("write_queue_drained", exp_mem.size(), 32'd0);

        // SET_REG 5 = 0x7E
        push_reg(4'h5, 8'h7E);
        send_byte(8'h03); send_byte(8'h05); send_byte(8'h7E);
        idle_cycles(3);
        check("reg_queue_drained", exp_reg.size(), 32'd0);

        // Address wrap at 0xFFFF
        push_mem(16'hFFFF, 8'h11);
        push_mem(16'h0000, 8'h22);
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h02); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        idle_cycles(4);
        check("wrap_queue_drained", exp_mem.size(), 32'd0);

        // Scan-out stall while a data byte is pending
        push_mem(16'h1000, 8'h55);
        push_mem(16'h1001, 8'h66);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h02); send_byte(8'h02);
        disp_busy = 1'b1;
        send_byte(8'h55);
        cmd_byte  = 8'h66;
        cmd_avail = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_no_mem_we", {31'd0, mem_we}, 32'd0);
            check("stall_no_ack", {31'd0, cmd_ack}, 32'd0);
            check("stall_seq_busy", {31'd0, seq_busy}, 32'd1);
        end
        disp_busy = 1'b0;
        @(posedge clk);
        #1;
        check("stall_release_mem_we", {31'd0, mem_we}, 32'd1);
        wait_ack();
        idle_cycles(4);
        check("stall_queue_drained", exp_mem.size(), 32'd0);

        // Reset while a write is stalled in commit
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h02); send_byte(8'h05);
        disp_busy = 1'b1;
        send_byte(8'hAA);
        idle_cycles(1);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        nrst      = 1'b1;
        disp_busy = 1'b0;
        idle_cycles(2);
        check("midrst_no_write", {31'd0, mem_we}, 32'd0);
        push_reg(4'h9, 8'hC3);
        send_byte(8'h03); send_byte(8'h09); send_byte(8'hC3);
        push_mem(16'h0000, 8'h77);
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h77);
        idle_cycles(4);
        check("midrst_reg_drained", exp_reg.size(), 32'd0);
        check("midrst_mem_drained", exp_mem.size(), 32'd0);

        // Unknown opcodes
        send_byte(8'h7F); send_byte(8'h7F); send_byte(8'h00);
        idle_cycles(2);
`ifdef CMDSEQ_ERRCNT_EN
        check("err_count_two", {24'd0, err_count}, 32'd2);
`else
        check("err_count_two", {24'd0, err_count}, 32'd0);
`endif
        check("err_seq_busy", {31'd0, seq_busy}, 32'd0);
        for (int i = 0; i < 300; i++) send_byte(8'h7F);
        idle_cycles(2);
`ifdef CMDSEQ_ERRCNT_EN
        check("err_count_sat", {24'd0, err_count}, 32'hFF);
`else
        check("err_count_sat", {24'd0, err_count}, 32'd0);
`endif
        check("err_seq_busy_end", {31'd0, seq_busy}, 32'd0);
        check("final_mem_queue", exp_mem.size(), 32'd0);
        check("final_reg_queue", exp_reg.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
